// File: rtl/key_buf_ctrl.sv
// Key buffer controller: sequences host commands into clear, parallel-load and
// streamed-write operations on an external key buffer and tracks key validity.
module key_buf_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_len,
    output logic        cmd_rdy,
    input  logic [31:0] din,
    input  logic        din_vld,
    output logic        din_rdy,
    input  logic        abort,
    input  logic        key_rel,
    output logic        key_vld,
    output logic [2:0]  key_src,
    output logic        err,
    output logic        k_buf_clr,
    output logic        k_buf_en,
    output logic [1:0]  k_buf_op,
    output logic [31:0] wr_d,
    output logic        wr_en,
    output logic        k_buf_wr,
    input  logic        rcv_nxtk
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CLR   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_STRM  = 3'd4,
        ST_RDY   = 3'd5,
        ST_PURGE = 3'd6
    } state_t;

    localparam logic [2:0] OP_STREAM = 3'b100;

    // Opcodes 000..011 select a parallel-load source.
    function automatic logic op_is_load(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Opcodes 110 and 111 are undefined.
    function automatic logic op_is_legal(input logic [2:0] op);
        return !(op[2] & op[1]);
    endfunction

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [3:0]  len_r;
    logic        strm_pend_r;
    logic        strm_act_r;
    logic        cmd_rdy_r;
    logic        key_vld_r;
    logic [2:0]  key_src_r;
    logic        err_r;
    logic        clr_r;
    logic        en_r;
    logic [1:0]  op_r;
    logic        cmd_acc_s;

    assign cmd_acc_s = cmd_vld & cmd_rdy_r;

    // Controller state machine with registered strobes and status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= 5'd0;
            len_r       <= 4'd0;
            strm_pend_r <= 1'b0;
            strm_act_r  <= 1'b0;
            cmd_rdy_r   <= 1'b0;
            key_vld_r   <= 1'b0;
            key_src_r   <= 3'b000;
            err_r       <= 1'b0;
            clr_r       <= 1'b0;
            en_r        <= 1'b0;
            op_r        <= 2'b00;
        end else begin
            err_r <= 1'b0;
            clr_r <= 1'b0;
            en_r  <= 1'b0;
            op_r  <= 2'b00;
            case (state_r)
                // First INIT cycle raises the clear; the second (clear visible) leaves.
                ST_INIT: begin
                    if (clr_r) begin
                        state_r   <= ST_IDLE;
                        cmd_rdy_r <= 1'b1;
                    end else begin
                        clr_r <= 1'b1;
                    end
                end
                ST_IDLE, ST_RDY: begin
                    if (cmd_acc_s) begin
                        if (!op_is_legal(cmd_op)) begin
                            err_r <= 1'b1;
                        end else begin
                            cmd_rdy_r <= 1'b0;
                            key_vld_r <= 1'b0;
                            key_src_r <= 3'b000;
                            if (op_is_load(cmd_op)) begin
                                state_r <= ST_LOAD;
                                en_r    <= 1'b1;
                                op_r    <= cmd_op[1:0];
                            end else begin
                                state_r     <= ST_CLR;
                                clr_r       <= 1'b1;
                                strm_pend_r <= ~cmd_op[0];
                                cnt_r       <= 5'd0;
                                len_r       <= cmd_len;
                            end
                        end
                    end else if ((state_r == ST_RDY) && key_rel) begin
                        state_r   <= ST_PURGE;
                        clr_r     <= 1'b1;
                        cmd_rdy_r <= 1'b0;
                        key_vld_r <= 1'b0;
                        key_src_r <= 3'b000;
                    end
                end
                ST_LOAD: begin
                    state_r   <= ST_RDY;
                    key_vld_r <= 1'b1;
                    key_src_r <= {1'b0, op_r};
                    cmd_rdy_r <= 1'b1;
                end
                ST_CLR: begin
                    strm_pend_r <= 1'b0;
                    if (strm_pend_r) begin
                        state_r    <= ST_STRM;
                        strm_act_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        cmd_rdy_r <= 1'b1;
                    end
                end
                // Words are counted on the buffer's write echo, not on the handshake.
                ST_STRM: begin
                    if (abort) begin
                        state_r    <= ST_PURGE;
                        err_r      <= 1'b1;
                        clr_r      <= 1'b1;
                        strm_act_r <= 1'b0;
                    end else if (rcv_nxtk) begin
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == {1'b0, len_r}) begin
                            state_r    <= ST_RDY;
                            strm_act_r <= 1'b0;
                            key_vld_r  <= 1'b1;
                            key_src_r  <= OP_STREAM;
                            cmd_rdy_r  <= 1'b1;
                        end
                    end
                end
                ST_PURGE: begin
                    state_r   <= ST_IDLE;
                    cmd_rdy_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    strm_pend_r <= 1'b0;
                    strm_act_r  <= 1'b0;
                    cmd_rdy_r   <= 1'b0;
                    key_vld_r   <= 1'b0;
                    key_src_r   <= 3'b000;
                end
            endcase
        end
    end

    // Stream data passes straight through; an abort suppresses the same-cycle beat.
    assign wr_en     = (state_r == ST_STRM) & din_vld & ~abort;
    assign wr_d      = din;
    assign din_rdy   = strm_act_r;
    assign k_buf_wr  = strm_act_r;
    assign cmd_rdy   = cmd_rdy_r;
    assign key_vld   = key_vld_r;
    assign key_src   = key_src_r;
    assign err       = err_r;
    assign k_buf_clr = clr_r;
    assign k_buf_en  = en_r;
    assign k_buf_op  = op_r;

endmodule

// File: tb/tb_key_buf_ctrl.sv
// Randomized self-checking bench for key_buf_ctrl against a transaction-level
// model of key validity, expected strobe pulses and streamed write data.
module tb_key_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic        cmd_rdy;
    logic [31:0] din;
    logic        din_vld;
    logic        din_rdy;
    logic        abort;
    logic        key_rel;
    logic        key_vld;
    logic [2:0]  key_src;
    logic        err;
    logic        k_buf_clr;
    logic        k_buf_en;
    logic [1:0]  k_buf_op;
    logic [31:0] wr_d;
    logic        wr_en;
    logic        k_buf_wr;
    logic        rcv_nxtk;

    int n_cmp = 0;
    int n_mis = 0;
    int obs_clr = 0;
    int obs_err = 0;
    int exp_clr = 0;
    int exp_err = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic        m_vld;
    logic [2:0]  m_src;

    always #5 clk = ~clk;

    // Key buffer echoes every accepted write in the same cycle.
    assign rcv_nxtk = wr_en & k_buf_wr;

    key_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_rdy(cmd_rdy), .din(din), .din_vld(din_vld), .din_rdy(din_rdy), .abort(abort),
        .key_rel(key_rel), .key_vld(key_vld), .key_src(key_src), .err(err),
        .k_buf_clr(k_buf_clr), .k_buf_en(k_buf_en), .k_buf_op(k_buf_op), .wr_d(wr_d),
        .wr_en(wr_en), .k_buf_wr(k_buf_wr), .rcv_nxtk(rcv_nxtk)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle observer: strobe exclusivity, idle load select, pulse tallies, writes.
    always @(negedge clk) begin
        chk("excl", 32'((int'(k_buf_clr) + int'(k_buf_en) + int'(wr_en)) <= 1), 32'd1);
        chk("op_idle", k_buf_en ? 2'b00 : k_buf_op, 32'd0);
        if (k_buf_clr) obs_clr++;
        if (err) obs_err++;
        if (wr_en && k_buf_wr) obs_q.push_back(wr_d);
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic st();
        #3;
    endtask

    task automatic do_reset(input int hold);
        nc();
        rst_n = 1'b0; cmd_vld = 1'b0; din_vld = 1'b0; abort = 1'b0; key_rel = 1'b0;
        repeat (hold) nc();
        st();
        chk("rst_clr", k_buf_clr, 0);   chk("rst_rdy", cmd_rdy, 0);
        chk("rst_vld", key_vld, 0);     chk("rst_err", err, 0);
        chk("rst_drdy", din_rdy, 0);    chk("rst_en", k_buf_en, 0);
        chk("rst_wrm", k_buf_wr, 0);    chk("rst_src", key_src, 0);
        chk("rst_op", k_buf_op, 0);     chk("rst_wr", wr_en, 0);
        nc(); rst_n = 1'b1;
        nc(); st();
        chk("init_clr", k_buf_clr, 1);  chk("init_rdy", cmd_rdy, 0);
        exp_clr++;
        nc(); st();
        chk("init_clr_end", k_buf_clr, 0); chk("init_rdy_end", cmd_rdy, 1);
        chk("init_vld", key_vld, 0);
        m_vld = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] len, input logic rel);
        nc();
        cmd_vld = 1'b1; cmd_op = op; cmd_len = len; key_rel = rel;
        st();
        chk("cmd_rdy", cmd_rdy, 1);
        nc();
        cmd_vld = 1'b0; key_rel = 1'b0; cmd_op = 3'($urandom); cmd_len = 4'($urandom);
    endtask

    task automatic do_load(input logic [2:0] op, input logic rel);
        issue(op, 4'($urandom), rel);
        st();
        chk("ld_en", k_buf_en, 1);      chk("ld_op", k_buf_op, op[1:0]);
        chk("ld_vld0", key_vld, 0);     chk("ld_clr", k_buf_clr, 0);
        chk("ld_rdy0", cmd_rdy, 0);
        nc(); st();
        chk("ld_vld", key_vld, 1);      chk("ld_src", key_src, op);
        chk("ld_rdy", cmd_rdy, 1);
        m_vld = 1'b1; m_src = op;
    endtask

    task automatic do_clear();
        issue(3'b101, 4'($urandom), 1'b0);
        st();
        chk("clr_clr", k_buf_clr, 1);   chk("clr_vld", key_vld, 0);
        exp_clr++;
        nc(); st();
        chk("clr_rdy", cmd_rdy, 1);     chk("clr_vld1", key_vld, 0);
        m_vld = 1'b0;
    endtask

    task automatic do_illegal(input logic [2:0] op);
        issue(op, 4'($urandom), 1'b0);
        st();
        chk("ill_err", err, 1);         chk("ill_vld", key_vld, m_vld);
        chk("ill_rdy", cmd_rdy, 1);     chk("ill_clr", k_buf_clr, 0);
        if (m_vld) chk("ill_src", key_src, m_src);
        exp_err++;
        nc(); st();
        chk("ill_err1", err, 0);        chk("ill_vld1", key_vld, m_vld);
    endtask

    task automatic do_release();
        nc(); key_rel = 1'b1; st();
        nc(); key_rel = 1'b0; st();
        chk("rel_clr", k_buf_clr, 1);   chk("rel_vld", key_vld, 0);
        chk("rel_rdy0", cmd_rdy, 0);
        exp_clr++;
        nc(); st();
        chk("rel_rdy", cmd_rdy, 1);     chk("rel_clr1", k_buf_clr, 0);
        m_vld = 1'b0;
    endtask

    task automatic do_noise();
        nc();
        abort = 1'b1;
        key_rel = m_vld ? 1'b0 : 1'($urandom_range(0, 1));
        st();
        nc(); abort = 1'b0; key_rel = 1'b0; st();
        chk("nz_err", err, 0);          chk("nz_rdy", cmd_rdy, 1);
        chk("nz_vld", key_vld, m_vld);  chk("nz_clr", k_buf_clr, 0);
    endtask

    // Stream len+1 words, or stop early at abort_at / rst_at (-1 disables each).
    task automatic do_stream(input int len, input int abort_at, input int rst_at,
                             input int gap_at, input bit rnd_gap);
        int stop;
        logic [31:0] v;
        issue(3'b100, 4'(len), 1'b0);
        st();
        chk("s_clr", k_buf_clr, 1);     chk("s_vld0", key_vld, 0);
        chk("s_drdy0", din_rdy, 0);
        exp_clr++;
        m_vld = 1'b0;
        stop = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : len + 1);
        for (int i = 0; i < stop; i++) begin
            nc();
            if (i == gap_at || (rnd_gap && $urandom_range(0, 3) == 0)) begin
                din_vld = 1'b0; st();
                chk("gap_rdy", din_rdy, 1); chk("gap_wr", wr_en, 0);
                nc();
            end
            v = $urandom; din = v; din_vld = 1'b1; st();
            chk("beat_rdy", din_rdy, 1);    chk("beat_wr", wr_en, 1);
            chk("beat_d", wr_d, v);
            exp_q.push_back(v);
        end
        if (rst_at >= 0) begin
            do_reset(1);
        end else if (abort_at >= 0) begin
            nc();
            din = $urandom; din_vld = 1'b1; abort = 1'b1; st();
            chk("ab_wr", wr_en, 0);
            nc(); abort = 1'b0; din_vld = 1'b0; st();
            chk("ab_err", err, 1);      chk("ab_clr", k_buf_clr, 1);
            chk("ab_vld", key_vld, 0);
            exp_err++; exp_clr++;
            nc(); st();
            chk("ab_rdy", cmd_rdy, 1);  chk("ab_vld1", key_vld, 0);
            chk("ab_drdy", din_rdy, 0);
        end else begin
            nc();
            din = $urandom; din_vld = 1'b1; st();
            chk("x_drdy", din_rdy, 0);  chk("x_wr", wr_en, 0);
            chk("s_vld", key_vld, 1);   chk("s_src", key_src, 3'b100);
            chk("s_rdy", cmd_rdy, 1);
            nc(); din_vld = 1'b0;
            m_vld = 1'b1; m_src = 3'b100;
        end
        chk("wr_cnt", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("wr_data", obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r;
        int len;
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = 3'b000; cmd_len = 4'd0;
        din = 32'd0; din_vld = 1'b0; abort = 1'b0; key_rel = 1'b0;
        m_vld = 1'b0; m_src = 3'b000;

        do_reset(2);
        do_load(3'b001, 1'b0);
        do_release();
        do_stream(3, -1, -1, 2, 1'b0);
        do_load(3'b000, 1'b1);
        do_illegal(3'b110);
        do_stream(15, 7, -1, -1, 1'b0);
        do_noise();
        do_stream(5, -1, 2, -1, 1'b1);
        do_load(3'b011, 1'b0);
        do_reset(1);

        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            len = $urandom_range(0, 15);
            if (r <= 2) begin
                do_load(3'($urandom_range(0, 3)), m_vld ? 1'($urandom_range(0, 1)) : 1'b0);
            end else if (r == 3) begin
                do_clear();
            end else if (r <= 5) begin
                case ($urandom_range(0, 5))
                    0:       do_stream(len, $urandom_range(0, len), -1, -1, 1'b1);
                    1:       do_stream(len, -1, $urandom_range(0, len), -1, 1'b1);
                    default: do_stream(len, -1, -1, -1, 1'b1);
                endcase
            end else if (r == 6) begin
                do_illegal(3'($urandom_range(6, 7)));
            end else if (r <= 8 && m_vld) begin
                do_release();
            end else if (r == 9 && $urandom_range(0, 1) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                do_noise();
            end
        end

        repeat (2) nc();
        chk("clr_total", obs_clr, exp_clr);
        chk("err_total", obs_err, exp_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
